// File: rtl/mips32_boot_loader_if.sv
// Byte-stream input and memory write port of the MIPS32 boot loader.
// The master side drives the stream and sinks the writes; the loader is the slave.
interface mips32_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips32_boot_loader.sv
// Program-image loader: parses a framed byte stream into sequential word writes, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module mips32_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 reload,
    mips32_boot_loader_if.slave  bus,
    output logic                 cpu_hold,
    output logic                 pc_clear,
    output logic                 done,
    output logic                 error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // Where the frame goes once the last data word (or an empty length) is seen.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state, state_next;
    logic [15:0] len_q;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accept;
    logic [15:0] len_rx;
    logic        word_last;
    logic        enter_done;

    assign bus.in_ready = (state != S_DONE);
    assign cpu_hold     = (state != S_DONE);
    assign done         = (state == S_DONE);
    assign error        = (state == S_ERR);

    assign accept     = bus.in_valid && bus.in_ready;
    assign len_rx     = {len_q[15:8], bus.in_data};
    assign word_last  = (word_cnt == len_q - 16'd1);
    assign enter_done = (state_next == S_DONE) && (state != S_DONE);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept && bus.in_data == SYNC) state_next = S_LEN_HI;
            S_LEN_HI: if (accept) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_rx} > DEPTH_W) state_next = S_ERR;
                    else if (len_rx == 16'd0)     state_next = S_TAIL;
                    else                          state_next = S_DATA;
                end
            end
            S_DATA:   if (accept && byte_cnt == 2'd3 && word_last) state_next = S_TAIL;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:    if (accept) state_next = (bus.in_data == csum_q) ? S_DONE : S_ERR;
`endif
            S_DONE:   state_next = S_DONE;
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_IDLE;
        endcase
        if (reload) state_next = S_IDLE;
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            len_q         <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            asm_q         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            pc_clear      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            pc_clear   <= enter_done;
            if (reload) begin
                // A byte accepted on the reload edge is dropped; no partial word is written.
                word_cnt <= '0;
                byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end else if (accept) begin
                case (state)
                    S_IDLE: begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q   <= '0;
`endif
                    end
                    S_LEN_HI: begin
                        len_q[15:8] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q      <= csum_q ^ bus.in_data;
`endif
                    end
                    S_LEN_LO: begin
                        len_q[7:0] <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ bus.in_data;
`endif
                    end
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q   <= csum_q ^ bus.in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= word_cnt[ADDR_W-1:0];
                            bus.mem_wdata <= {asm_q, bus.in_data};
                            word_cnt      <= word_cnt + 16'd1;
                        end else begin
                            asm_q <= {asm_q[15:0], bus.in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips32_boot_loader.sv
// Scoreboard bench for mips32_boot_loader: frames built from random images, writes checked by a monitor.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_mips32_boot_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk1   = 1'b0;
    logic rst_n  = 1'b1;
    logic reload = 1'b0;
    logic cpu_hold, pc_clear, done, error;

    mips32_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips32_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .reload   (reload),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .pc_clear (pc_clear),
        .done     (done),
        .error    (error)
    );

    always #5 clk1 = ~clk1;

    int n_pass  = 0;
    int n_total = 0;
    int pc_seen = 0;
    int pc_exp  = 0;

    wr_t         exp_wr[$];
    logic [31:0] img[$];
    logic [7:0]  frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk1) begin : monitor
        wr_t e;
        if (rst_n) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(bus.mem_we), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("wr_data", bus.mem_wdata, e.data);
                end
            end
            if (pc_clear) begin
                pc_seen++;
                check("pc_clear_with_done", 32'(done), 32'd1);
                check("pc_clear_with_release", 32'(cpu_hold), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        int g;
        @(negedge clk1);
        if (gaps) begin
            g = $urandom_range(0, 2);
            bus.in_valid = 1'b0;
            repeat (g) @(negedge clk1);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk1);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        else @(posedge clk1);
    endtask

    task automatic send_bytes(input int first, input int count, input bit gaps);
        for (int i = first; i < first + count; i++) send_byte(frame[i], gaps);
    endtask

    task automatic send_junk(input int count);
        logic [7:0] b;
        for (int i = 0; i < count; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, 1'b1);
        end
    endtask

    // Frame = sync, big-endian word count, big-endian words, optional XOR of length and data bytes.
    task automatic make_frame(input logic [15:0] n_len, input bit bad_sum);
        logic [7:0] sum;
        logic [31:0] w;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(n_len[15:8]);
        frame.push_back(n_len[7:0]);
        sum = n_len[15:8] ^ n_len[7:0];
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int k = 3; k >= 0; k--) begin
                frame.push_back(w[8*k +: 8]);
                sum = sum ^ w[8*k +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(bad_sum ? (sum ^ 8'h03) : sum);
`else
        if (bad_sum) sum = ~sum;
`endif
    endtask

    task automatic expect_words(input int count);
        wr_t e;
        for (int i = 0; i < count; i++) begin
            e.addr = i[ADDR_W-1:0];
            e.data = img[i];
            exp_wr.push_back(e);
        end
    endtask

    task automatic rand_image(input int count);
        img.delete();
        for (int i = 0; i < count; i++) img.push_back($urandom());
    endtask

    task automatic check_done();
        @(negedge clk1);
        bus.in_valid = 1'b0;
        pc_exp++;
        check("done", 32'(done), 32'd1);
        check("cpu_hold_released", 32'(cpu_hold), 32'd0);
        check("pc_clear_pulse", 32'(pc_clear), 32'd1);
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        check("error_in_done", 32'(error), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        if (img.size() > 0) check("last_write_with_release", 32'(bus.mem_we), 32'd1);
`endif
        @(negedge clk1);
        check("pc_clear_one_cycle", 32'(pc_clear), 32'd0);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic check_error();
        @(negedge clk1);
        bus.in_valid = 1'b0;
        check("error", 32'(error), 32'd1);
        check("cpu_hold_in_error", 32'(cpu_hold), 32'd1);
        check("done_in_error", 32'(done), 32'd0);
        check("pc_clear_in_error", 32'(pc_clear), 32'd0);
        check("in_ready_in_error", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_reload();
        @(negedge clk1);
        reload       = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk1);
        reload = 1'b0;
        check("reload_error_clear", 32'(error), 32'd0);
        check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
        check("reload_in_ready", 32'(bus.in_ready), 32'd1);
        check("reload_done_clear", 32'(done), 32'd0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_pc_clear", 32'(pc_clear), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        repeat (3) @(negedge clk1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk1);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Single-word image from the reference frame.
        img.delete();
        img.push_back(32'hFC00_0000);
        make_frame(16'd1, 1'b0);
        expect_words(1);
        send_bytes(0, frame.size(), 1'b0);
        check_done();

        // Leading junk, then a 3-word program with random valid gaps.
        do_reload();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_junk(3);
        img.delete();
        img.push_back(32'h2801_000A);
        img.push_back(32'h2802_0014);
        img.push_back(32'h0022_1800);
        make_frame(16'd3, 1'b0);
        expect_words(3);
        send_bytes(0, frame.size(), 1'b1);
        check_done();

        // Random images.
        for (int k = 0; k < 4; k++) begin
            int n;
            do_reload();
            send_junk(k);
            n = $urandom_range(1, 6);
            rand_image(n);
            make_frame(16'(n), 1'b0);
            expect_words(n);
            send_bytes(0, frame.size(), 1'b1);
            check_done();
        end

        // Empty image.
        do_reload();
        img.delete();
        make_frame(16'd0, 1'b0);
        send_bytes(0, frame.size(), 1'b1);
        check_done();

        // Length one past DEPTH: error, bytes drained, then recovery.
        do_reload();
        img.delete();
        make_frame(16'h0401, 1'b0);
        send_bytes(0, 3, 1'b0);
        check_error();
        send_junk(3);
        check("error_sticky", 32'(error), 32'd1);
        do_reload();
        rand_image(2);
        make_frame(16'd2, 1'b0);
        expect_words(2);
        send_bytes(0, frame.size(), 1'b1);
        check_done();

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum: the word is written but the core is never released.
        do_reload();
        img.delete();
        img.push_back(32'hFC00_0000);
        make_frame(16'd1, 1'b1);
        expect_words(1);
        send_bytes(0, frame.size(), 1'b0);
        check_error();
`endif

        // Reload after two bytes of word 1: only word 0 is written.
        do_reload();
        rand_image(3);
        make_frame(16'd3, 1'b0);
        expect_words(1);
        send_bytes(0, 9, 1'b1);
        do_reload();
        repeat (3) @(negedge clk1);
        check("midload_hold", 32'(cpu_hold), 32'd1);
        rand_image(2);
        make_frame(16'd2, 1'b0);
        expect_words(2);
        send_bytes(0, frame.size(), 1'b1);
        check_done();

        // Reload on the same edge as a word's last byte drops it: no write.
        do_reload();
        rand_image(1);
        make_frame(16'd1, 1'b0);
        send_bytes(0, 6, 1'b0);
        @(negedge clk1);
        bus.in_data  = frame[6];
        bus.in_valid = 1'b1;
        reload       = 1'b1;
        @(negedge clk1);
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        check("reload_drop_no_write", 32'(bus.mem_we), 32'd0);
        check("reload_drop_in_ready", 32'(bus.in_ready), 32'd1);
        check("reload_drop_hold", 32'(cpu_hold), 32'd1);
        rand_image(1);
        make_frame(16'd1, 1'b0);
        expect_words(1);
        send_bytes(0, frame.size(), 1'b1);
        check_done();

        // Largest legal image: last write lands at DEPTH-1.
        do_reload();
        rand_image(DEPTH);
        make_frame(16'(DEPTH), 1'b0);
        expect_words(DEPTH);
        send_bytes(0, frame.size(), 1'b0);
        check_done();

        repeat (4) @(negedge clk1);
        check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
        check("pc_clear_count", 32'(pc_seen), 32'(pc_exp));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
